expmul_lanes: RTL and testbench
===============================

# expmul_lanes

Parametrised, lane-serialised successor of the single-shot exponential-multiply stage in the attention datapath. Computes v_out[i] = exp(a − b) · v_in[i] over a VEC_LEN-element vector using a base-2 shift-and-linear exp approximation and LANES multipliers time-shared across the vector. It sits between the running-max/score logic and the output accumulator, rescaling value or partial-output vectors when the running maximum changes.

## Interface
- SCORE_W, 16: signed width of a_in, b_in, in Q(SCORE_W−FRAC_W).FRAC_W
- ELEM_W, 16: signed width of each vector element
- VEC_LEN, 8: elements per vector
- LANES, 2: multipliers; VEC_LEN % LANES != 0 is an elaboration error
- FRAC_W, 8: fractional bits of scores and of the internal scale
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- vld_in  in  1  upstream operands valid
- rdy_out  out  1  block can accept operands
- a_in  in  SCORE_W  score (signed)
- b_in  in  SCORE_W  running max (signed)
- v_in  in  VEC_LEN*ELEM_W  element i at [i*ELEM_W +: ELEM_W], signed
- vld_out  out  1  result valid
- rdy_in  in  1  downstream ready
- v_out  out  VEC_LEN*ELEM_W  result, same packing
- sat_out  out  1  a_in > b_in was seen for this result (d clamped)

## Operation
- States: IDLE, EXP, MUL, DONE. B = VEC_LEN/LANES beats.
- rdy_out = (state==IDLE) || (state==DONE && rdy_in). Accept = vld_in && rdy_out: register a, b, v; go to EXP.
- EXP (1 cycle), registers scale:
  - d = a − b in SCORE_W+1 bits; if d > 0: d = 0, sat = 1, else sat = 0.
  - L = round(log2(e)·2^FRAC_W) (369 at FRAC_W=8); t = (d·L) >>> FRAC_W (floor).
  - ip = t >>> FRAC_W (≤ 0); f = t & (2^FRAC_W−1).
  - scale = (2^FRAC_W + f) >> (−ip); −ip > FRAC_W → scale = 0. scale ≤ 2^FRAC_W.
- MUL: beat k (0..B−1) writes v_out elements k·LANES..k·LANES+LANES−1 as (v[i]·scale) >>> FRAC_W (floor, full-width product, result fits ELEM_W). After beat B−1 go to DONE.
- DONE: vld_out = 1; v_out, sat_out held stable until rdy_in. rdy_in && !vld_in → IDLE; rdy_in && vld_in → accept new operands, go to EXP.
- vld_in ignored outside accept; operands held in registers, upstream may change inputs after accept.

## Timing
- Reset (rst low, async): state IDLE, vld_out 0, rdy_out 1 (combinational from IDLE), v_out 0, sat_out 0, internal registers 0. Reset mid-operation discards partial result; no vld_out pulse after release.
- Accept at edge E0 → EXP; scale at E1; beats at E1+1..E1+B; vld_out high after edge E0+B+1 (B+1 cycles; 5 at defaults).
- Throughput: one vector per B+2 cycles with back-to-back DONE→EXP; vld_out low the cycle after consume.
- Backpressure: rdy_in low in DONE holds all outputs indefinitely; rdy_out stays 0.
- v_out elements may change while vld_out = 0; never while vld_out = 1.

## Test plan
- Reset then a=b=0x0100, v=[100,−100,1,−1,32767,−32768,0,7] → after 5 cycles vld_out=1, v_out = v exactly, sat_out=0.
- a=0x0000, b=0x0100 (d=−1.0): scale=99; v[0]=100 → 38, v[1]=−100 → −39, sat_out=0.
- a=0x0200, b=0x0100 (a>b): d clamped, v_out = v, sat_out=1.
- a=0x8000, b=0x7FFF (d ≈ −256.0): scale=0, all v_out = 0.
- Hold rdy_in=0 for 10 cycles in DONE with vld_in=1 → outputs stable, rdy_out=0; raise rdy_in → second vector accepted same edge, its vld_out B+1 cycles later.
- Pull rst low during MUL beat 2 → vld_out, v_out, sat_out 0 immediately; rdy_out=1 after; no spurious result.

Source files
------------

// File: rtl/expmul_lanes.sv
// Lane-serialised exp(a-b)*v rescale stage: base-2 shift-and-linear exp,
// LANES multipliers walked across the vector over VEC_LEN/LANES beats.

module expmul_lane #(
    parameter int ELEM_W = 16,
    parameter int FRAC_W = 8
) (
    input  logic [ELEM_W-1:0] i_elem,
    input  logic [FRAC_W:0]   i_scale,
    output logic [ELEM_W-1:0] o_res
);
    localparam int PW = ELEM_W + FRAC_W + 2;

    logic signed [PW-1:0] w_prod;
    logic                 w_unused_bits;

    // scale <= 2^FRAC_W, so the floored product always fits back into ELEM_W
    assign w_prod = $signed({{(FRAC_W+2){i_elem[ELEM_W-1]}}, i_elem})
                  * $signed({{(ELEM_W+1){1'b0}}, i_scale});
    assign o_res         = w_prod[FRAC_W +: ELEM_W];
    assign w_unused_bits = ^{w_prod[PW-1 -: 2], w_prod[FRAC_W-1:0]};
endmodule

module expmul_lanes #(
    parameter int SCORE_W = 16,
    parameter int ELEM_W  = 16,
    parameter int VEC_LEN = 8,
    parameter int LANES   = 2,
    parameter int FRAC_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      vld_in,
    output logic                      rdy_out,
    input  logic [SCORE_W-1:0]        a_in,
    input  logic [SCORE_W-1:0]        b_in,
    input  logic [VEC_LEN*ELEM_W-1:0] v_in,
    output logic                      vld_out,
    input  logic                      rdy_in,
    output logic [VEC_LEN*ELEM_W-1:0] v_out,
    output logic                      sat_out
);
    localparam int BEATS   = VEC_LEN / LANES;
    localparam int BW      = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int DW      = SCORE_W + 1;
    localparam int PW      = DW + FRAC_W + 2;
    localparam int SHW     = $clog2(FRAC_W + 2);
    localparam int LOG2E_Q = $rtoi(1.4426950408889634 * (2.0 ** FRAC_W) + 0.5);

    generate
        if ((VEC_LEN % LANES) != 0) begin : g_bad_cfg
            $error("expmul_lanes: VEC_LEN must be a multiple of LANES");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_EXP, S_MUL, S_DONE} state_t;

    state_t                            r_state, w_nxt;
    logic [SCORE_W-1:0]                r_a, r_b;
    logic [VEC_LEN-1:0][ELEM_W-1:0]    r_v, r_vout;
    logic [FRAC_W:0]                   r_scale;
    logic                              r_sat;
    logic [BW-1:0]                     r_beat;

    logic                              w_acc, w_sat, w_last;
    logic signed [DW-1:0]              w_d_raw, w_d;
    logic signed [PW-1:0]              w_dl, w_nip;
    logic [FRAC_W-1:0]                 w_f;
    logic [FRAC_W:0]                   w_scale;
    logic [LANES-1:0][ELEM_W-1:0]      w_res;
    logic [VEC_LEN+LANES-1:0][ELEM_W-1:0] w_vcat;
    logic                              w_unused;

    assign rdy_out = (r_state == S_IDLE) || ((r_state == S_DONE) && rdy_in);
    assign w_acc   = vld_in && rdy_out;
    assign w_last  = (r_beat == BW'(BEATS - 1));
    assign vld_out = (r_state == S_DONE);
    assign v_out   = r_vout;
    assign sat_out = r_sat;

    // d*log2(e) carries 2*FRAC_W fraction bits: integer part above, f just below
    assign w_d_raw = $signed({r_a[SCORE_W-1], r_a}) - $signed({r_b[SCORE_W-1], r_b});
    assign w_sat   = !w_d_raw[DW-1] && (w_d_raw != '0);
    assign w_d     = w_sat ? '0 : w_d_raw;
    assign w_dl    = $signed({{(PW-DW){w_d[DW-1]}}, w_d}) * $signed(PW'(LOG2E_Q));
    assign w_f     = w_dl[2*FRAC_W-1:FRAC_W];
    assign w_nip   = -(w_dl >>> (2*FRAC_W));
    assign w_scale = (w_nip > PW'(FRAC_W)) ? '0 : ({1'b1, w_f} >> w_nip[SHW-1:0]);

    genvar gl;
    generate
        for (gl = 0; gl < LANES; gl++) begin : g_lane
            expmul_lane #(.ELEM_W(ELEM_W), .FRAC_W(FRAC_W)) u_lane (
                .i_elem  (r_v[gl]),
                .i_scale (r_scale),
                .o_res   (w_res[gl])
            );
        end
    endgenerate

    // results enter at the top and slide down, so beat 0 ends at element 0
    assign w_vcat   = {w_res, r_vout};
    assign w_unused = ^{w_dl[FRAC_W-1:0], w_vcat[LANES-1:0]};

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_acc) w_nxt = S_EXP;
            S_EXP:   w_nxt = S_MUL;
            S_MUL:   if (w_last) w_nxt = S_DONE;
            S_DONE:  if (rdy_in) w_nxt = vld_in ? S_EXP : S_IDLE;
            default: w_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_v     <= '0;
            r_vout  <= '0;
            r_scale <= '0;
            r_sat   <= 1'b0;
            r_beat  <= '0;
        end else begin
            if (w_acc) begin
                r_a <= a_in;
                r_b <= b_in;
                r_v <= v_in;
            end
            if (r_state == S_EXP) begin
                r_scale <= w_scale;
                r_sat   <= w_sat;
                r_beat  <= '0;
            end
            if (r_state == S_MUL) begin
                r_v    <= r_v >> (LANES*ELEM_W);
                r_vout <= w_vcat[VEC_LEN+LANES-1:LANES];
                r_beat <= r_beat + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_expmul_lanes.sv
// Scoreboard bench for expmul_lanes: directed vectors, monitor-side checking.

module tb_expmul_lanes;
    localparam int VW = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic          vld_in, rdy_out, vld_out, rdy_in, sat_out;
    logic [15:0]   a_in, b_in;
    logic [VW-1:0] v_in, v_out;

    typedef struct {
        logic [VW-1:0] v;
        logic          sat;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    expmul_lanes dut (
        .clk     (clk),
        .rst     (rst),
        .vld_in  (vld_in),
        .rdy_out (rdy_out),
        .a_in    (a_in),
        .b_in    (b_in),
        .v_in    (v_in),
        .vld_out (vld_out),
        .rdy_in  (rdy_in),
        .v_out   (v_out),
        .sat_out (sat_out)
    );

    always #5 clk = ~clk;

    function automatic logic [VW-1:0] pk(input int e0, e1, e2, e3, e4, e5, e6, e7);
        return {16'(e7), 16'(e6), 16'(e5), 16'(e4), 16'(e3), 16'(e2), 16'(e1), 16'(e0)};
    endfunction

    task automatic chk(input string nm, input logic [VW+1:0] act, input logic [VW+1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [VW-1:0] v,
                        input logic [VW-1:0] ev, input logic es, input bit push);
        int   n;
        bit   ok;
        exp_t e;
        n = 0;
        ok = 0;
        a_in = a; b_in = b; v_in = v; vld_in = 1'b1;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = rdy_out;
            if (ok && push) begin
                e.v = ev; e.sat = es;
                sb.push_back(e);
            end
            @(posedge clk);
            n++;
        end
        #1;
        vld_in = 1'b0;
        a_in = ~a; b_in = ~b; v_in = ~v;
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!vld_out && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && vld_out && rdy_in) begin
                if (sb.size() == 0) begin
                    chk("spurious_vld", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("result_v", {2'b0, v_out}, {2'b0, e.v});
                    chk("result_sat", {{VW{1'b0}}, 1'b0, sat_out}, {{VW{1'b0}}, 1'b0, e.sat});
                end
            end
        end
    end

    initial begin : main
        logic [VW-1:0] vT, eT2, vA, vB, eB;
        int            cyc;
        bit            seen;
        vT  = pk(100, -100, 1, -1, 32767, -32768, 0, 7);
        eT2 = pk(38, -39, 0, -1, 12671, -12672, 0, 2);
        vA  = pk(1, 2, 3, 4, 5, 6, 7, 8);
        vB  = pk(256, 512, -256, 1000, -1000, 2560, 10, -10);
        eB  = pk(99, 198, -99, 386, -387, 990, 3, -4);

        rst = 1'b0; vld_in = 1'b0; rdy_in = 1'b1;
        a_in = '0; b_in = '0; v_in = '0;
        #3;
        chk("rst_vld_out", {{VW+1{1'b0}}, vld_out}, 0);
        chk("rst_rdy_out", {{VW+1{1'b0}}, rdy_out}, 1);
        chk("rst_v_out", {2'b0, v_out}, 0);
        chk("rst_sat_out", {{VW+1{1'b0}}, sat_out}, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        send(16'h0100, 16'h0100, vT, vT, 1'b0, 1);
        wait_done(cyc); chk("lat_unity", cyc, 5);
        send(16'h0000, 16'h0100, vT, eT2, 1'b0, 1);
        wait_done(cyc); chk("lat_exp_m1", cyc, 5);
        send(16'h0200, 16'h0100, vT, vT, 1'b1, 1);
        wait_done(cyc); chk("lat_sat", cyc, 5);
        send(16'h8000, 16'h7FFF, vT, '0, 1'b0, 1);
        wait_done(cyc); chk("lat_zero", cyc, 5);
        @(posedge clk); #1;

        // backpressure with the next operands already waiting
        rdy_in = 1'b0;
        send(16'h0000, 16'h0000, vA, vA, 1'b0, 1);
        wait_done(cyc); chk("lat_bp", cyc, 5);
        a_in = 16'h0000; b_in = 16'h0100; v_in = vB; vld_in = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("bp_hold", {vld_out, rdy_out, v_out}, {1'b1, 1'b0, vA});
        end
        @(posedge clk); #1;
        rdy_in = 1'b1;
        begin
            exp_t e;
            e.v = eB; e.sat = 1'b0;
            sb.push_back(e);
        end
        @(negedge clk);
        chk("bp_rdy_out", {{VW+1{1'b0}}, rdy_out}, 1);
        @(posedge clk); #1;
        vld_in = 1'b0; v_in = ~vB; a_in = 16'h7FFF;
        chk("bp_vld_drop", {{VW+1{1'b0}}, vld_out}, 0);
        wait_done(cyc); chk("lat_b2b", cyc, 5);
        @(posedge clk); #1;

        // reset while the multiply beats are in flight
        send(16'h0200, 16'h0100, vB, '0, 1'b0, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("mid_rst_outs", {vld_out, sat_out, v_out}, 0);
        chk("mid_rst_rdy", {{VW+1{1'b0}}, rdy_out}, 1);
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (vld_out) seen = 1;
        end
        chk("no_spurious", {{VW+1{1'b0}}, seen}, 0);
        chk("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
